// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the IO output path.
//   IO_DATA_W  - width of an IO store payload (32)
//   IO_ADDR_W  - default IO port address width (8)
//   IO_DEPTH   - default posted-write FIFO depth (4)
//   io_entry_t - one queued store, packed {addr, data}, at the default widths
//   io_cnt_w() - width needed to hold an occupancy of 0..depth
package io_pkg;

  localparam int unsigned IO_DATA_W = 32;
  localparam int unsigned IO_ADDR_W = 8;
  localparam int unsigned IO_DEPTH  = 4;

  typedef struct packed {
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_DATA_W-1:0] data;
  } io_entry_t;

  function automatic int unsigned io_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/io_out_buffer_if.sv
// io_out_buffer_if: store-side and peripheral-side signals of the IO output
// buffer, bundled for drop-in port compatibility.
//   Store side     : IOWrite, IOAddr, IOData (in), IOStall (out)
//   Peripheral side: IOOutValid, IOOutAddr, IOOutData (out), IOOutReady (in)
//   Status         : IOCount, IOLastOut (out)
//   slave  modport - the buffer itself
//   master modport - memory stage / peripheral / testbench driving the buffer
interface io_out_buffer_if
  import io_pkg::*;
#(
  parameter int unsigned DEPTH  = IO_DEPTH,
  parameter int unsigned ADDR_W = IO_ADDR_W
);

  localparam int unsigned CNT_W = io_cnt_w(DEPTH);

  logic                 IOWrite;
  logic [ADDR_W-1:0]    IOAddr;
  logic [IO_DATA_W-1:0] IOData;
  logic                 IOStall;
  logic                 IOOutValid;
  logic [ADDR_W-1:0]    IOOutAddr;
  logic [IO_DATA_W-1:0] IOOutData;
  logic                 IOOutReady;
  logic [CNT_W-1:0]     IOCount;
  logic [IO_DATA_W-1:0] IOLastOut;

  modport slave (
    input  IOWrite, IOAddr, IOData, IOOutReady,
    output IOStall, IOOutValid, IOOutAddr, IOOutData, IOCount, IOLastOut
  );

  modport master (
    output IOWrite, IOAddr, IOData, IOOutReady,
    input  IOStall, IOOutValid, IOOutAddr, IOOutData, IOCount, IOLastOut
  );

endinterface

// File: rtl/io_fifo_ptr.sv
// io_fifo_ptr: read/write pointer and occupancy registers for a
// power-of-two FIFO of DEPTH entries.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push_req     - producer wants to write
//   pop_req      - consumer wants to read
//   push, pop    - qualified strobes (push refused when full, pop when empty)
//   wptr, rptr   - write / read slot indices, wrap DEPTH-1 -> 0
//   count        - occupied entries, 0..DEPTH
//   full, empty  - decoded from the registered count
module io_fifo_ptr
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = IO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req,
  input  logic                       pop_req,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wptr,
  output logic [$clog2(DEPTH)-1:0]   rptr,
  output logic [io_cnt_w(DEPTH)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = io_cnt_w(DEPTH);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO refuses the push even if it pops in the same cycle; the
  // producer holds its store and retries next cycle.
  assign push = push_req & ~full;
  assign pop  = pop_req  & ~empty;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (push) begin
      wptr <= wptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
    end else if (pop) begin
      rptr <= rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_out_buffer.sv
// io_out_buffer: posted-write buffer for the memory-mapped IO output port.
// IO stores from the memory stage are queued in a DEPTH-entry FIFO and
// drained in order to the peripheral over a valid/ready handshake; the
// pipeline is stalled while the FIFO is full so no store is dropped.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - io_out_buffer_if.slave:
//                IOWrite/IOAddr/IOData in, IOStall out (store side)
//                IOOutValid/IOOutAddr/IOOutData out, IOOutReady in (peripheral)
//                IOCount, IOLastOut out (status / loopback)
// Build option IO_READBACK_EN: when defined, IOLastOut holds the data of the
// most recent entry accepted by the peripheral (0 until the first pop);
// when undefined, IOLastOut is tied to zero.
module io_out_buffer
  import io_pkg::*;
#(
  parameter int unsigned DEPTH  = IO_DEPTH,
  parameter int unsigned ADDR_W = IO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  io_out_buffer_if.slave    bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = io_cnt_w(DEPTH);

  // Same layout as io_entry_t, but sized by this instance's ADDR_W.
  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [IO_DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  io_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (bus.IOWrite),
    .pop_req  (bus.IOOutReady),
    .push     (push),
    .pop      (pop),
    .wptr     (wptr),
    .rptr     (rptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Storage carries no reset; stale slots are masked by the empty check.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{addr: bus.IOAddr, data: bus.IOData};
    end
  end

  assign head = mem[rptr];

  assign bus.IOStall    = full;
  assign bus.IOOutValid = ~empty;
  assign bus.IOCount    = count;
  assign bus.IOOutAddr  = empty ? '0 : head.addr;
  assign bus.IOOutData  = empty ? '0 : head.data;

`ifdef IO_READBACK_EN
  logic [IO_DATA_W-1:0] last_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_out <= '0;
    end else if (pop) begin
      last_out <= head.data;
    end
  end

  assign bus.IOLastOut = last_out;
`else
  assign bus.IOLastOut = '0;
`endif

endmodule

// File: tb/tb_io_out_buffer.sv
module tb_io_out_buffer;
  import io_pkg::*;

`ifdef IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  io_out_buffer_if #(.DEPTH(4), .ADDR_W(8)) bus ();

  io_out_buffer #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample/drive 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [7:0] a,
                           input logic [31:0] d);
    chk({tag, ".count"}, 32'(bus.IOCount), 32'(cnt));
    chk({tag, ".valid"}, 32'(bus.IOOutValid), 32'(cnt != 0));
    chk({tag, ".stall"}, 32'(bus.IOStall), 32'(cnt == 4));
    chk({tag, ".addr"},  32'(bus.IOOutAddr), 32'(a));
    chk({tag, ".data"},  bus.IOOutData, d);
  endtask

  logic [31:0] hd_tab  [12];
  int          cnt_tab [12];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.IOWrite    = 1'b0;
    bus.IOAddr     = '0;
    bus.IOData     = '0;
    bus.IOOutReady = 1'b0;

    // ---- reset state
    #12;
    chk_state("reset", 0, 8'h00, 32'h0);
    chk("reset.last", bus.IOLastOut, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_state("post_reset", 0, 8'h00, 32'h0);

    // ---- single store
    bus.IOOutReady = 1'b1;
    bus.IOWrite = 1'b1; bus.IOAddr = 8'h10; bus.IOData = 32'h3C;
    chk("no_fallthrough.valid", 32'(bus.IOOutValid), 32'h0);
    tick();
    bus.IOWrite = 1'b0;
    chk_state("single.visible", 1, 8'h10, 32'h3C);
    tick();
    chk_state("single.popped", 0, 8'h00, 32'h0);
    chk("single.last", bus.IOLastOut, RB ? 32'h3C : 32'h0);
    tick();  // empty + ready has no effect
    chk_state("empty_ready", 0, 8'h00, 32'h0);

    // ---- fill and stall
    bus.IOOutReady = 1'b0;
    bus.IOWrite = 1'b1;
    bus.IOAddr = 8'h20; bus.IOData = 32'h55; tick(); chk_state("fill1", 1, 8'h20, 32'h55);
    bus.IOAddr = 8'h21; bus.IOData = 32'h7F; tick(); chk_state("fill2", 2, 8'h20, 32'h55);
    bus.IOAddr = 8'h22; bus.IOData = 32'h16; tick(); chk_state("fill3", 3, 8'h20, 32'h55);
    bus.IOAddr = 8'h23; bus.IOData = 32'hE6; tick(); chk_state("fill4", 4, 8'h20, 32'h55);
    bus.IOAddr = 8'h24; bus.IOData = 32'h99;
    tick(); chk_state("full_hold1", 4, 8'h20, 32'h55);
    tick(); chk_state("full_hold2", 4, 8'h20, 32'h55);

    // ---- release: first pop frees a slot, held 0x99 enters next edge
    bus.IOOutReady = 1'b1;
    tick(); chk_state("rel1", 3, 8'h21, 32'h7F);
    chk("rel1.last", bus.IOLastOut, RB ? 32'h55 : 32'h0);
    tick(); chk_state("rel2", 3, 8'h22, 32'h16);
    bus.IOWrite = 1'b0;
    tick(); chk_state("rel3", 2, 8'h23, 32'hE6);
    tick(); chk_state("rel4", 1, 8'h24, 32'h99);
    tick(); chk_state("rel5", 0, 8'h00, 32'h0);
    chk("rel.last", bus.IOLastOut, RB ? 32'h99 : 32'h0);

    // ---- simultaneous push/pop at count 2, 8 cycles (pointers wrap twice)
    bus.IOOutReady = 1'b0;
    bus.IOWrite = 1'b1;
    bus.IOAddr = 8'h30; bus.IOData = 32'hA0; tick();
    bus.IOAddr = 8'h31; bus.IOData = 32'hA1; tick();
    chk_state("pp.pre", 2, 8'h30, 32'hA0);
    bus.IOOutReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.IOAddr = 8'h50 + 8'(k);
      bus.IOData = 32'hB0 + 32'(k);
      tick();
      if (k == 0) chk_state("pp", 2, 8'h31, 32'hA1);
      else        chk_state("pp", 2, 8'h50 + 8'(k - 1), 32'hB0 + 32'(k - 1));
    end
    bus.IOWrite = 1'b0;
    tick(); chk_state("pp.drain1", 1, 8'h57, 32'hB7);
    tick(); chk_state("pp.drain0", 0, 8'h00, 32'h0);

    // ---- backpressure: ready toggles, stores C0..C5 then drain
    hd_tab = '{32'hC0, 32'hC1, 32'hC1, 32'hC2, 32'hC2, 32'hC3,
               32'hC3, 32'hC4, 32'hC4, 32'hC5, 32'hC5, 32'h0};
    cnt_tab = '{1, 1, 2, 2, 3, 3, 3, 2, 2, 1, 1, 0};
    for (int i = 0; i < 12; i++) begin
      bus.IOOutReady = (i % 2) == 1;
      bus.IOWrite    = (i < 6);
      bus.IOAddr     = 8'h40 + 8'(i);
      bus.IOData     = 32'hC0 + 32'(i);
      tick();
      chk_state("bp", cnt_tab[i],
                (cnt_tab[i] == 0) ? 8'h00 : 8'h40 + 8'(hd_tab[i] - 32'hC0),
                hd_tab[i]);
    end
    chk("bp.last", bus.IOLastOut, RB ? 32'hC5 : 32'h0);

    // ---- reset mid-stream with 3 entries queued
    bus.IOOutReady = 1'b0;
    bus.IOWrite = 1'b1;
    bus.IOAddr = 8'h60; bus.IOData = 32'hD0; tick();
    bus.IOAddr = 8'h61; bus.IOData = 32'hD1; tick();
    bus.IOAddr = 8'h62; bus.IOData = 32'hD2; tick();
    bus.IOWrite = 1'b0;
    chk_state("mid.pre", 3, 8'h60, 32'hD0);
    #1 rst_n = 1'b0;
    #1;
    chk_state("mid.reset", 0, 8'h00, 32'h0);
    chk("mid.last", bus.IOLastOut, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk_state("mid.after", 0, 8'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_out_buffer.md
# io_out_buffer

Posted-write buffer for the processor's memory-mapped output port. It is the output-direction counterpart of the IO input path that feeds the write-back stage. The memory stage issues IO stores into a small FIFO, and the block drains them to the external peripheral over a valid/ready handshake. When the FIFO is full, the block stalls the pipeline so that no store is ever dropped.

## Interface
- DEPTH, 4: FIFO entries; a power of two, at least 2.
- ADDR_W, 8: IO port address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- IOWrite  in  1  memory stage requests an IO store this cycle.
- IOAddr  in  ADDR_W  store port address.
- IOData  in  32  store data.
- IOStall  out  1  FIFO full; the pipeline must hold the store.
- IOOutValid  out  1  head entry is presented to the peripheral.
- IOOutAddr  out  ADDR_W  head address.
- IOOutData  out  32  head data.
- IOOutReady  in  1  peripheral accepts the head.
- IOCount  out  $clog2(DEPTH+1)  occupied entries.
- IOLastOut  out  32  last data accepted by the peripheral (see Configuration).

## Operation
- Push: at a posedge with IOWrite=1 and IOStall=0, {IOAddr, IOData} is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: at a posedge with IOOutValid=1 and IOOutReady=1, the read pointer increments modulo DEPTH.
- Count: increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- IOStall = (IOCount == DEPTH), decoded combinationally from the registered count.
- When full, a push is refused even if a pop occurs in the same cycle. The pipeline retries the next cycle.
- The memory stage must hold IOWrite/IOAddr/IOData stable while IOStall=1.
- IOOutValid = (IOCount != 0).
- IOOutAddr and IOOutData are read from the head entry.
- Entries leave in strict FIFO order. Data is never reordered or merged.
- The peripheral may hold IOOutReady low indefinitely. Head outputs stay stable while IOOutValid=1 and no pop occurs.
- Reset values: IOCount=0, pointers=0, IOOutValid=0, IOStall=0, IOOutAddr=0, IOOutData=0, IOLastOut=0.
- Reset mid-operation discards every queued entry immediately (asynchronous). Storage contents need not be cleared, but the head outputs are forced to 0 while IOCount=0.

## Timing
- Push-to-visible latency is 1 cycle. A store pushed at edge N drives IOOutValid=1 after edge N if the FIFO was empty.
- There is no fall-through: an empty FIFO with IOWrite=1 does not present data in the same cycle.
- Throughput is 1 push and 1 pop per cycle sustained.
- A full FIFO with a pop at edge N deasserts IOStall after edge N. The held store is accepted at edge N+1.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- Empty + IOOutReady=1 has no effect.
- Full + IOWrite=1 with no pop has no effect, and IOStall stays 1.

## Configuration
- IO_READBACK_EN defined: IOLastOut is a register loaded with IOOutData on every pop. It reads 0 until the first pop, and is intended to be returned as the IO input source in write-back for echo/loopback.
- IO_READBACK_EN undefined: the register is absent, IOLastOut is tied to 32'b0, and the port list is unchanged.

## Structure
- Shared package io_pkg holds IO_DATA_W=32, the default ADDR_W, and the typedef io_entry_t (packed {addr, data}).
- One sub-module, io_fifo_ptr: a pointer/count register pair with push/pop/full/empty outputs, parameterised by DEPTH.
- The storage array and handshake glue live in io_out_buffer.

## Test plan
- Single store: reset, push {0x10, 0x0000003C} with IOOutReady=1 -> IOOutValid=1 for exactly one cycle, presenting 0x10/0x3C; IOCount returns 0; IOLastOut=0x3C when the macro is defined.
- Fill and stall: IOOutReady=0, push 0x55, 0x7F, 0x16, 0xE6 -> IOCount=4 and IOStall=1; a fifth push of 0x99 is held and not accepted while IOOutReady stays 0.
- Release: from the full state, assert IOOutReady=1 -> outputs 0x55 then 0x7F; IOStall drops after the first pop; 0x99 is accepted on the next edge; the final drain order is 0x55, 0x7F, 0x16, 0xE6, 0x99.
- Simultaneous push/pop: with IOCount=2, push while popping for 8 cycles -> IOCount stays 2, data stays in order, and the pointers wrap twice.
- Backpressure hold: IOOutReady toggles 0/1 every cycle across 6 stores -> head outputs are stable whenever IOOutReady=0 and no entry is duplicated or lost.
- Reset mid-stream: with 3 entries queued, pulse rst_n low between edges -> IOOutValid=0, IOCount=0 and IOStall=0 immediately; IOLastOut=0.
